// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the 1RW SRAM arbiter.
package sram_arb_pkg;

   localparam int ADDR_W_DEF       = 8;
   localparam int DATA_W_DEF       = 66;
   localparam int STARVE_LIMIT_DEF = 4;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } arb_state_e;

endpackage

// File: rtl/sram_1rw_arbiter_if.sv
// Requester and SRAM-macro signal bundle for sram_1rw_arbiter.
interface sram_1rw_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              rd_req_valid;
   logic              rd_req_ready;
   logic [ADDR_W-1:0] rd_req_addr;
   logic              rd_resp_valid;
   logic [DATA_W-1:0] rd_resp_data;
   logic              wr_req_valid;
   logic              wr_req_ready;
   logic [ADDR_W-1:0] wr_req_addr;
   logic [DATA_W-1:0] wr_req_data;
   logic              sram_en;
   logic              sram_wmode;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;
   logic              init_done;

   modport slave (
      input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, sram_rdata,
      output rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
             sram_en, sram_wmode, sram_addr, sram_wdata, init_done
   );

   modport master (
      output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, sram_rdata,
      input  rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
             sram_en, sram_wmode, sram_addr, sram_wdata, init_done
   );

endinterface

// File: rtl/sram_arb_clear_seq.sv
// Zero-fill address sequencer; only built when SRAM_ARB_CLEAR_EN is defined.
module sram_arb_clear_seq
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   output logic [ADDR_W-1:0] clr_ptr,
   output logic              done
);

   always_ff @(posedge clock) begin
      if (reset) begin
         clr_ptr <= '0;
      end else if (en) begin
         clr_ptr <= clr_ptr + ADDR_W'(1);
      end
   end

   // The pointer wraps back to 0 on the last write, ready for the next clear.
   assign done = en && (clr_ptr == {ADDR_W{1'b1}});

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Read/write arbiter for one 1RW SRAM macro with read starvation guard.
// Optional zero-fill of the array after reset: define SRAM_ARB_CLEAR_EN.
module sram_1rw_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clock,
   input  logic reset,
   sram_1rw_arbiter_if.slave bus
);

   localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [DATA_W-1:0] ZERO_WORD  = '0;
   localparam logic [0:0]        ST_RUN     = 1'(RUN);
`ifdef SRAM_ARB_CLEAR_EN
   localparam logic [0:0]        ST_CLEAR   = 1'(CLEAR);
   localparam logic [0:0]        ST_RESET   = ST_CLEAR;
`else
   localparam logic [0:0]        ST_RESET   = ST_RUN;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == STARVE_MAX) ? v : v + CNT_W'(1);
   endfunction

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic             run;
   logic             starved;
   logic             rd_gnt;
   logic             wr_gnt;
   logic             rd_vld_p1;
   logic             init_done_q;

`ifdef SRAM_ARB_CLEAR_EN
   logic              clr_active;
   logic              clr_done;
   logic [ADDR_W-1:0] clr_ptr;

   assign clr_active = !reset && (state == ST_CLEAR);

   sram_arb_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clock   (clock),
      .reset   (reset),
      .en      (state == ST_CLEAR),
      .clr_ptr (clr_ptr),
      .done    (clr_done)
   );

   assign state_nxt = (state == ST_CLEAR && clr_done) ? ST_RUN : state;
`else
   assign state_nxt = ST_RUN;
`endif

   // Valids are never qualified by ready, so the grant can be purely combinational.
   assign run     = !reset && (state == ST_RUN);
   assign starved = (starve_cnt == STARVE_MAX);
   assign rd_gnt  = run && bus.rd_req_valid && (!bus.wr_req_valid || starved);
   assign wr_gnt  = run && bus.wr_req_valid && !(bus.rd_req_valid && starved);

   assign bus.rd_req_ready = rd_gnt;
   assign bus.wr_req_ready = wr_gnt;

   always_comb begin
      bus.sram_en    = 1'b0;
      bus.sram_wmode = 1'b0;
      bus.sram_addr  = {ADDR_W{1'b0}};
      bus.sram_wdata = ZERO_WORD;
`ifdef SRAM_ARB_CLEAR_EN
      if (clr_active) begin
         bus.sram_en    = 1'b1;
         bus.sram_wmode = 1'b1;
         bus.sram_addr  = clr_ptr;
      end else
`endif
      if (wr_gnt) begin
         bus.sram_en    = 1'b1;
         bus.sram_wmode = 1'b1;
         bus.sram_addr  = bus.wr_req_addr;
         bus.sram_wdata = bus.wr_req_data;
      end else if (rd_gnt) begin
         bus.sram_en    = 1'b1;
         bus.sram_addr  = bus.rd_req_addr;
      end
   end

   // p0 -> p1: read grant becomes response valid as the macro returns data.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_RESET;
         starve_cnt  <= '0;
         rd_vld_p1   <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         init_done_q <= (state_nxt == ST_RUN);
         rd_vld_p1   <= rd_gnt;
         if (rd_gnt) begin
            starve_cnt <= '0;
         end else if (bus.rd_req_valid) begin
            starve_cnt <= sat_inc(starve_cnt);
         end
      end
   end

   assign bus.rd_resp_valid = rd_vld_p1;
   assign bus.rd_resp_data  = bus.sram_rdata;
   assign bus.init_done     = init_done_q;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Scoreboard bench for sram_1rw_arbiter with a behavioural SRAM and reference model.
module tb_sram_1rw_arbiter;

   localparam int AW    = 8;
   localparam int DW    = 66;
   localparam int LIMIT = 4;
   localparam int DEPTH = 1 << AW;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   sram_1rw_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

   sram_1rw_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc)
   );

   // Behavioural 1RW macro: registered read data, held when not reading.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clock) begin
      if (ifc.sram_en) begin
         if (ifc.sram_wmode) mem[ifc.sram_addr] <= ifc.sram_wdata;
         else                ifc.sram_rdata     <= mem[ifc.sram_addr];
      end
   end

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: array contents as seen by granted requests, plus starvation count.
   logic [DW-1:0] ref_mem   [DEPTH];
   bit            ref_known [DEPTH];
   int            starve = 0;
   logic [DW-1:0] exp_q [$];
   bit            known_q [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   logic [DW-1:0] mon_d;
   bit            mon_k;
   always @(posedge clock) begin
      #2;
      if (ifc.rd_resp_valid === 1'b1) begin
         check("resp_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            mon_d = exp_q.pop_front();
            mon_k = known_q.pop_front();
            if (mon_k) check("rd_data", ifc.rd_resp_data, mon_d);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time %0t reached, bench did not finish", $time);
      $fatal(1);
   end

   task automatic do_reset(input int n);
      reset = 1'b1;
      ifc.rd_req_valid = 1'b1;
      ifc.wr_req_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #3;
         check("rst_rd_ready", ifc.rd_req_ready, 0);
         check("rst_wr_ready", ifc.wr_req_ready, 0);
         check("rst_sram_en", ifc.sram_en, 0);
         check("rst_resp_valid", ifc.rd_resp_valid, 0);
         check("rst_init_done", ifc.init_done, 0);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      ifc.rd_req_valid = 1'b0;
      ifc.wr_req_valid = 1'b0;
      starve = 0;
      exp_q.delete();
      known_q.delete();
   endtask

   // One clock of requester activity; entered and left at posedge+1.
   task automatic cycle(input bit rv, input logic [AW-1:0] ra, input bit wv,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        output bit rg, output bit wg);
      bit erg, ewg;
      ifc.rd_req_valid = rv;
      ifc.rd_req_addr  = ra;
      ifc.wr_req_valid = wv;
      ifc.wr_req_addr  = wa;
      ifc.wr_req_data  = wd;
      erg = rv && (!wv || starve == LIMIT);
      ewg = wv && !erg;
      #3;
      rg = ifc.rd_req_ready;
      wg = ifc.wr_req_ready;
      check("rd_grant", rg, erg);
      check("wr_grant", wg, ewg);
      check("sram_en", ifc.sram_en, erg || ewg);
      if (ewg) begin
         check("wr_wmode", ifc.sram_wmode, 1);
         check("wr_addr", ifc.sram_addr, wa);
         check("wr_wdata", ifc.sram_wdata, wd);
         ref_mem[wa]   = wd;
         ref_known[wa] = 1'b1;
      end
      if (erg) begin
         check("rd_wmode", ifc.sram_wmode, 0);
         check("rd_addr", ifc.sram_addr, ra);
         exp_q.push_back(ref_mem[ra]);
         known_q.push_back(ref_known[ra]);
         starve = 0;
      end else if (rv) begin
         starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      end
      @(posedge clock); #1;
   endtask

   task automatic idle();
      bit rg, wg;
      cycle(1'b0, '0, 1'b0, '0, '0, rg, wg);
   endtask

`ifdef SRAM_ARB_CLEAR_EN
   task automatic run_clear(input int n, output int bad);
      bad = 0;
      for (int i = 0; i < n; i++) begin
         #3;
         if (!(ifc.sram_en === 1'b1 && ifc.sram_wmode === 1'b1 && ifc.sram_addr === 8'(i) &&
               ifc.sram_wdata === '0 && ifc.init_done === 1'b0 &&
               ifc.rd_req_ready === 1'b0 && ifc.wr_req_ready === 1'b0)) bad++;
         @(posedge clock); #1;
      end
   endtask

   task automatic model_cleared();
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i]   = '0;
         ref_known[i] = 1'b1;
      end
   endtask
`endif

   initial begin
      bit rg, wg;
      bit prv, pwv;
      logic [AW-1:0] pra, pwa;
      logic [DW-1:0] pwd;
      logic [9:0] rd_pat, wr_pat;
      int bad;

      reset = 1'b1;
      ifc.rd_req_valid = 1'b0;
      ifc.rd_req_addr  = '0;
      ifc.wr_req_valid = 1'b0;
      ifc.wr_req_addr  = '0;
      ifc.wr_req_data  = '0;
      for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

      do_reset(3);

`ifdef SRAM_ARB_CLEAR_EN
      run_clear(DEPTH, bad);
      check("clear_writes", bad, 0);
      #3;
      check("init_done_after_clear", ifc.init_done, 1);
      check("clear_stops", ifc.sram_en, 0);
      @(posedge clock); #1;
      model_cleared();
      cycle(1'b1, 8'hFF, 1'b0, '0, '0, rg, wg);
      idle();

      do_reset(1);
      run_clear(100, bad);
      check("clear_first_100", bad, 0);
      #3;
      check("clr_ptr_100", ifc.sram_addr, 8'd100);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      run_clear(DEPTH, bad);
      check("clear_restart", bad, 0);
      check("init_done_after_restart", ifc.init_done, 1);
      model_cleared();
`else
      cycle(1'b0, '0, 1'b1, 8'h05, 66'h2_1234_5678_9ABC_DEF0, rg, wg);
      check("init_done_no_clear", ifc.init_done, 1);
      idle();
`endif

      cycle(1'b0, '0, 1'b1, 8'h10, 66'h3_DEAD_BEEF_0000_0001, rg, wg);
      cycle(1'b1, 8'h10, 1'b0, '0, '0, rg, wg);
      check("resp_latency", ifc.rd_resp_valid, 1);
      idle();
      check("resp_single_pulse", ifc.rd_resp_valid, 0);

      prv = 1'b1;
      pra = 8'h40;
      for (int i = 0; i < 10; i++) begin
         cycle(prv, pra, 1'b1, 8'(8'h30 + i), {2'($urandom), $urandom, $urandom}, rg, wg);
         rd_pat[i] = rg;
         wr_pat[i] = wg;
         if (rg) pra = pra + 8'd1;
      end
      check("contention_rd", rd_pat, 10'b10_0001_0000);
      check("contention_wr", wr_pat, 10'b01_1110_1111);

      cycle(1'b1, 8'h20, 1'b1, 8'h20, 66'h55, rg, wg);
      check("collide_wr_first", {rg, wg}, 2'b01);
      cycle(1'b1, 8'h20, 1'b0, '0, '0, rg, wg);
      check("collide_rd_next", rg, 1);
      idle();

      prv = 1'b0;
      pwv = 1'b0;
      pra = '0;
      pwa = '0;
      pwd = '0;
      for (int i = 0; i < 1500; i++) begin
         if (!prv && $urandom_range(0, 99) < 55) begin
            prv = 1'b1;
            pra = 8'($urandom_range(0, 15));
         end
         if (!pwv && $urandom_range(0, 99) < 55) begin
            pwv = 1'b1;
            pwa = 8'($urandom_range(0, 15));
            pwd = {2'($urandom), $urandom, $urandom};
         end
         cycle(prv, pra, pwv, pwa, pwd, rg, wg);
         if (rg) prv = 1'b0;
         if (wg) pwv = 1'b0;
      end

      idle();
      idle();
      idle();
      check("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
